// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between download writes (priority)
// and round-robin game read requesters, routing in-order read data back via a tag FIFO.
module sdram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_WIDTH-1:0]           dl_addr,
  input  logic [DATA_WIDTH-1:0]           dl_data,
  input  logic                            dl_req,
  output logic                            dl_ack,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  input  logic [NUM_PORTS-1:0]            p_req,
  output logic [NUM_PORTS-1:0]            p_ack,
  output logic [NUM_PORTS-1:0]            p_valid,
  output logic [DATA_WIDTH-1:0]           p_q,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [DATA_WIDTH-1:0]           sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [DATA_WIDTH-1:0]           sdram_q
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TAG_DEPTH);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [GW-1:0] grant, last_grant, pick;
  logic [GW-1:0] tags [TAG_DEPTH];
  logic [TW-1:0] wr_ptr, rd_ptr;
  logic [TW:0] count;
  logic push, pop, full;
  assign full   = count == (TW+1)'(TAG_DEPTH);
  assign push   = state == REQ && sdram_ack && !sdram_we;
  assign pop    = sdram_valid && count != '0;
  assign dl_ack = state == REQ && sdram_ack && sdram_we;
  assign p_ack  = push ? NUM_PORTS'(1) << grant : '0;
  // Scan downward so the nearest requester after last_grant is the one left in pick.
  always_comb begin
    pick = '0;
    for (int k = NUM_PORTS; k >= 1; k--)
      if (p_req[(int'(last_grant) + k) % NUM_PORTS]) pick = GW'((int'(last_grant) + k) % NUM_PORTS);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      p_valid    <= '0;
      p_q        <= '0;
    end else begin
      p_valid <= pop ? NUM_PORTS'(1) << tags[rd_ptr] : '0;
      if (pop) begin
        p_q    <= sdram_q;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        tags[wr_ptr] <= grant;
        wr_ptr       <= wr_ptr + 1'b1;
        last_grant   <= grant;
      end
      count <= count + (TW+1)'(push) - (TW+1)'(pop);
      if (state == IDLE) begin
        if (dl_req) begin
          state      <= REQ;
          sdram_req  <= 1'b1;
          sdram_we   <= 1'b1;
          sdram_addr <= dl_addr;
          sdram_data <= dl_data;
        end else if (!full && |p_req) begin
          state      <= REQ;
          sdram_req  <= 1'b1;
          sdram_we   <= 1'b0;
          sdram_addr <= p_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          grant      <= pick;
        end
      end else if (sdram_ack) begin
        state     <= IDLE;
        sdram_req <= 1'b0;
      end
    end
  end
endmodule
